// File: rtl/boot_stream_loader.sv
// Boot stream loader: parses sync/count/instruction words from the UART, acks the host, then streams data words.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the program.
module boot_stream_loader #(
  parameter logic [31:0] MAX_INSTR = 32'd16384,
  parameter logic [7:0]  SYNC_BYTE = 8'h99,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  NAK_BYTE  = 8'hEE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rdata,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic        instr_ready,
  output logic        data_ready,
  output logic [31:0] content,
  output logic        program_loaded
);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_LEN   = 3'd1,
    S_INSTR = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK   = 3'd3,
`endif
    S_ACK   = 3'd4,
    S_NAK   = 3'd5,
    S_RUN   = 3'd6
  } state_t;

  state_t      r_state;
  logic [1:0]  r_byteIdx;
  logic [23:0] r_asm;
  logic [31:0] r_count;
  logic [31:0] r_wordCnt;
  logic        r_txStart;
  logic [7:0]  r_sdata;
  logic        r_instrReady;
  logic        r_dataReady;
  logic [31:0] r_content;
  logic        r_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_collect;
  logic        w_lastByte;
  logic [31:0] w_word;

  // ACK keeps assembling so data bytes sent while the ack is pending are not lost
  assign w_collect  = rx_ready && (r_state == S_LEN || r_state == S_INSTR ||
                                   r_state == S_ACK || r_state == S_RUN);
  assign w_lastByte = w_collect && (r_byteIdx == 2'd3);
  assign w_word     = {rdata, r_asm};

  always_ff @(posedge clock) begin
    if (reset || r_state == S_SYNC) begin
      r_byteIdx <= 2'd0;
      r_asm     <= 24'd0;
    end else if (w_collect) begin
      r_byteIdx <= r_byteIdx + 2'd1;
      case (r_byteIdx)
        2'd0:    r_asm[7:0]   <= rdata;
        2'd1:    r_asm[15:8]  <= rdata;
        2'd2:    r_asm[23:16] <= rdata;
        default: r_asm        <= r_asm;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_SYNC;
      r_count      <= 32'd0;
      r_wordCnt    <= 32'd0;
      r_txStart    <= 1'b0;
      r_sdata      <= 8'd0;
      r_instrReady <= 1'b0;
      r_dataReady  <= 1'b0;
      r_content    <= 32'd0;
      r_loaded     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= 8'd0;
`endif
    end else begin
      r_txStart    <= 1'b0;
      r_instrReady <= 1'b0;
      r_dataReady  <= 1'b0;
      case (r_state)
        S_SYNC: begin
          if (rx_ready && rdata == SYNC_BYTE) begin
            r_state <= S_LEN;
`ifdef LOADER_CHECKSUM_EN
            r_xor   <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (w_lastByte) begin
            r_count   <= w_word;
            r_wordCnt <= 32'd0;
            if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_ACK;
`endif
            end else if (w_word > MAX_INSTR) begin
              r_state <= S_NAK;
            end else begin
              r_state <= S_INSTR;
            end
          end
        end
        S_INSTR: begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_ready) r_xor <= r_xor ^ rdata;
`endif
          if (w_lastByte) begin
            r_instrReady <= 1'b1;
            r_content    <= w_word;
            r_wordCnt    <= r_wordCnt + 32'd1;
            if (r_wordCnt + 32'd1 == r_count) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_ACK;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_ready) r_state <= (rdata == r_xor) ? S_ACK : S_NAK;
        end
`endif
        S_ACK: begin
          r_sdata <= ACK_BYTE;
          if (!tx_busy) begin
            r_txStart <= 1'b1;
            r_loaded  <= 1'b1;
            r_state   <= S_RUN;
          end
          if (w_lastByte) begin
            r_dataReady <= 1'b1;
            r_content   <= w_word;
          end
        end
        S_NAK: begin
          r_sdata <= NAK_BYTE;
          if (!tx_busy) begin
            r_txStart <= 1'b1;
            r_state   <= S_SYNC;
          end
        end
        S_RUN: begin
          if (w_lastByte) begin
            r_dataReady <= 1'b1;
            r_content   <= w_word;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign tx_start       = r_txStart;
  assign sdata          = r_sdata;
  assign instr_ready    = r_instrReady;
  assign data_ready     = r_dataReady;
  assign content        = r_content;
  assign program_loaded = r_loaded;

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed self-checking bench for boot_stream_loader; follows LOADER_CHECKSUM_EN when it is defined.
module tb_boot_stream_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxReady = 1'b0;
  logic [7:0]  rdata = 8'd0;
  logic        txBusy = 1'b0;
  logic        txStart;
  logic [7:0]  sdata;
  logic        instrReady;
  logic        dataReady;
  logic [31:0] content;
  logic        programLoaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] instrQ[$];
  logic [31:0] dataQ[$];
  int          txCnt = 0;
  logic [7:0]  txByte = 8'd0;

  boot_stream_loader dut (
    .clock          (clock),
    .reset          (reset),
    .rx_ready       (rxReady),
    .rdata          (rdata),
    .tx_busy        (txBusy),
    .tx_start       (txStart),
    .sdata          (sdata),
    .instr_ready    (instrReady),
    .data_ready     (dataReady),
    .content        (content),
    .program_loaded (programLoaded)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Capture every strobe on the falling edge, away from the DUT's update edge
  always @(negedge clock) begin
    if (instrReady) instrQ.push_back(content);
    if (dataReady) dataQ.push_back(content);
    if (txStart) begin
      txCnt  = txCnt + 1;
      txByte = sdata;
    end
    if (instrReady && dataReady) begin
      bad = bad + 1;
      $error("[TB] FAIL strobe_overlap instr_ready=1 data_ready=1 required not both");
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clock);
    #1;
    rxReady = 1'b1;
    rdata   = b;
    @(posedge clock);
    #1;
    rxReady = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8]);
  endtask

  task automatic sendChecksum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(c);
`else
    if (c == 8'hFF) waitCycles(0);
`endif
  endtask

  task automatic clearMon();
    instrQ.delete();
    dataQ.delete();
    txCnt  = 0;
    txByte = 8'd0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    clearMon();
  endtask

  // Linear sequence of directed scenarios
  initial begin
    waitCycles(3);
    checkOutput("rst_tx_start", {31'd0, txStart}, 32'd0);
    checkOutput("rst_sdata", {24'd0, sdata}, 32'd0);
    checkOutput("rst_instr_ready", {31'd0, instrReady}, 32'd0);
    checkOutput("rst_data_ready", {31'd0, dataReady}, 32'd0);
    checkOutput("rst_content", content, 32'd0);
    checkOutput("rst_loaded", {31'd0, programLoaded}, 32'd0);
    reset = 1'b0;
    clearMon();

    // Two-word program, then streaming data in RUN
    applyStimulus(8'h99);
    sendWord(32'd2);
    sendWord(32'h00000013);
    sendWord(32'hDEADBEEF);
    sendChecksum(8'h31);
    waitCycles(4);
    checkOutput("t1_instr_cnt", instrQ.size(), 32'd2);
    checkOutput("t1_instr0", (instrQ.size() > 0) ? instrQ[0] : 32'hX, 32'h00000013);
    checkOutput("t1_instr1", (instrQ.size() > 1) ? instrQ[1] : 32'hX, 32'hDEADBEEF);
    checkOutput("t1_tx_cnt", txCnt, 32'd1);
    checkOutput("t1_tx_byte", {24'd0, txByte}, 32'h000000AA);
    checkOutput("t1_loaded", {31'd0, programLoaded}, 32'd1);

    clearMon();
    for (int i = 1; i <= 5; i++) applyStimulus(i[7:0]);
    waitCycles(3);
    checkOutput("t3_data_cnt", dataQ.size(), 32'd1);
    checkOutput("t3_data0", (dataQ.size() > 0) ? dataQ[0] : 32'hX, 32'h04030201);
    applyStimulus(8'h06);
    applyStimulus(8'h99);
    applyStimulus(8'h08);
    waitCycles(3);
    checkOutput("t3_data_cnt2", dataQ.size(), 32'd2);
    checkOutput("t3_data1", (dataQ.size() > 1) ? dataQ[1] : 32'hX, 32'h08990605);
    checkOutput("t3_no_instr", instrQ.size(), 32'd0);
    checkOutput("t3_still_loaded", {31'd0, programLoaded}, 32'd1);

    // Noise before sync, zero-length program
    doReset();
    applyStimulus(8'h55);
    applyStimulus(8'hAA);
    applyStimulus(8'h99);
    sendWord(32'd0);
    sendChecksum(8'h00);
    waitCycles(4);
    checkOutput("t2_tx_cnt", txCnt, 32'd1);
    checkOutput("t2_tx_byte", {24'd0, txByte}, 32'h000000AA);
    checkOutput("t2_loaded", {31'd0, programLoaded}, 32'd1);
    checkOutput("t2_no_instr", instrQ.size(), 32'd0);

    // Oversized counts are rejected, then a fresh session succeeds
    doReset();
    applyStimulus(8'h99);
    sendWord(32'h00004001);
    waitCycles(4);
    checkOutput("t4_tx_cnt", txCnt, 32'd1);
    checkOutput("t4_tx_byte", {24'd0, txByte}, 32'h000000EE);
    checkOutput("t4_loaded", {31'd0, programLoaded}, 32'd0);
    clearMon();
    applyStimulus(8'h99);
    sendWord(32'h01000000);
    waitCycles(4);
    checkOutput("t4_hi_count_nak", {24'd0, txByte}, 32'h000000EE);
    checkOutput("t4_hi_no_instr", instrQ.size(), 32'd0);
    clearMon();
    applyStimulus(8'h99);
    sendWord(32'd1);
    sendWord(32'h11223344);
    sendChecksum(8'h44);
    waitCycles(4);
    checkOutput("t4_fresh_instr", (instrQ.size() == 1) ? instrQ[0] : 32'hX, 32'h11223344);
    checkOutput("t4_fresh_tx", {24'd0, txByte}, 32'h000000AA);
    checkOutput("t4_fresh_loaded", {31'd0, programLoaded}, 32'd1);

    // UART busy while the ack is pending; data bytes keep flowing
    doReset();
    txBusy = 1'b1;
    applyStimulus(8'h99);
    sendWord(32'd0);
    sendChecksum(8'h00);
    sendWord(32'h0D0C0B0A);
    waitCycles(90);
    checkOutput("t5_busy_no_tx", txCnt, 32'd0);
    checkOutput("t5_busy_loaded", {31'd0, programLoaded}, 32'd0);
    checkOutput("t5_data_cnt", dataQ.size(), 32'd1);
    checkOutput("t5_data0", (dataQ.size() > 0) ? dataQ[0] : 32'hX, 32'h0D0C0B0A);
    txBusy = 1'b0;
    waitCycles(3);
    checkOutput("t5_tx_cnt", txCnt, 32'd1);
    checkOutput("t5_tx_byte", {24'd0, txByte}, 32'h000000AA);
    checkOutput("t5_loaded", {31'd0, programLoaded}, 32'd1);
    checkOutput("t5_data_cnt_final", dataQ.size(), 32'd1);

    // Reset in the middle of INSTR with a partial word outstanding
    doReset();
    applyStimulus(8'h99);
    sendWord(32'd2);
    sendWord(32'h00000013);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    checkOutput("t5r_instr_cnt", instrQ.size(), 32'd1);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("t5r_content", content, 32'd0);
    checkOutput("t5r_loaded", {31'd0, programLoaded}, 32'd0);
    checkOutput("t5r_sdata", {24'd0, sdata}, 32'd0);
    reset = 1'b0;
    clearMon();
    applyStimulus(8'h99);
    sendWord(32'd0);
    sendChecksum(8'h00);
    sendWord(32'h04030201);
    waitCycles(3);
    checkOutput("t5r_fresh_loaded", {31'd0, programLoaded}, 32'd1);
    checkOutput("t5r_fresh_data", (dataQ.size() == 1) ? dataQ[0] : 32'hX, 32'h04030201);

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch is rejected
    doReset();
    applyStimulus(8'h99);
    sendWord(32'd1);
    sendWord(32'h11223344);
    applyStimulus(8'h45);
    waitCycles(4);
    checkOutput("t6_bad_sum_tx", {24'd0, txByte}, 32'h000000EE);
    checkOutput("t6_bad_sum_loaded", {31'd0, programLoaded}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
